qsys_lab_sram_arb: RTL and testbench

Parametrised on-chip SRAM slave with two Avalon-MM slave ports (s1, s2) sharing one single-port memory bank. Replaces the fixed 32-bit × 4096 single-port SRAM in the Qsys lab system. Adds:
- configurable width and depth;
- an optional output register;
- explicit `readdatavalid` pipelining;
- round-robin arbitration with `waitrequest` back-pressure when both masters hit the bank in the same cycle.

---
 rtl/qsys_lab_sram_pkg.sv | 15 +
 rtl/qsys_lab_sram_bank.sv | 48 ++++
 rtl/qsys_lab_sram_arb.sv | 132 +++++++++++++
 tb/tb_qsys_lab_sram_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_lab_sram_pkg.sv
// rtl/qsys_lab_sram_pkg.sv - shared types for the dual-port arbitrated SRAM slave
package qsys_lab_sram_pkg;

  typedef enum logic {
    PORT_S1 = 1'b0,
    PORT_S2 = 1'b1
  } port_e;

  // One slot of the read-response pipeline: which port owns the returning word.
  typedef struct packed {
    logic  valid;
    port_e port;
  } rsp_t;

endpackage

// File: rtl/qsys_lab_sram_bank.sv
// rtl/qsys_lab_sram_bank.sv - single-port byte-enabled RAM, registered address, optional output register
module qsys_lab_sram_bank #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 12,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "",
  parameter int    BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_clken,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BE_W-1:0]   i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;

  // Memory array carries no reset so it maps onto block RAM and survives reset_n.
  always_ff @(posedge clk) begin
    if (i_clken) begin
      if (i_wr_en) begin
        for (int i = 0; i < BE_W; i++) begin
          if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
      if (i_rd_en) r_addr <= i_addr;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (i_clken) r_dout <= r_mem[r_addr];
      end
      assign o_rdata = r_dout;
    end else begin : g_comb
      assign o_rdata = r_mem[r_addr];
    end
  endgenerate

endmodule

// File: rtl/qsys_lab_sram_arb.sv
// rtl/qsys_lab_sram_arb.sv - two Avalon-MM slave ports round-robin arbitrated onto one SRAM bank
module qsys_lab_sram_arb
  import qsys_lab_sram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 12,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "",
  parameter int    BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,

  input  logic [ADDR_W-1:0] s2_address,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest
);

  localparam int RSP_DEPTH = 1 + OUT_REG;

  port_e             r_last;
  rsp_t              r_pipe [RSP_DEPTH];
  logic [DATA_W-1:0] r_hold1;
  logic [DATA_W-1:0] r_hold2;

  logic              w_req1;
  logic              w_req2;
  logic              w_gnt1;
  logic              w_gnt2;
  logic              w_gnt_any;
  logic              w_gnt_wr;
  logic              w_rd_fire;
  logic              w_run;
  port_e             w_gnt_port;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_bank_rdata;
  rsp_t              w_head;
  logic              w_v1;
  logic              w_v2;

  assign w_req1 = s1_chipselect & (s1_read | s1_write);
  assign w_req2 = s2_chipselect & (s2_read | s2_write);

  // On conflict the port that was not granted last wins.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt2 = 1'b0;
    if (w_req1 & w_req2) begin
      if (r_last == PORT_S2) w_gnt1 = 1'b1;
      else                   w_gnt2 = 1'b1;
    end else begin
      w_gnt1 = w_req1;
      w_gnt2 = w_req2;
    end
  end

  assign w_gnt_any  = w_gnt1 | w_gnt2;
  assign w_gnt_port = w_gnt2 ? PORT_S2 : PORT_S1;
  assign w_gnt_wr   = w_gnt2 ? s2_write : s1_write;
  assign w_rd_fire  = w_gnt_any & ~w_gnt_wr;
  assign w_run      = clken & reset_n;

  assign w_addr  = w_gnt2 ? s2_address    : s1_address;
  assign w_be    = w_gnt2 ? s2_byteenable : s1_byteenable;
  assign w_wdata = w_gnt2 ? s2_writedata  : s1_writedata;

  assign s1_waitrequest = (w_req1 & ~w_gnt1) | ~clken | ~reset_n;
  assign s2_waitrequest = (w_req2 & ~w_gnt2) | ~clken | ~reset_n;

  qsys_lab_sram_bank #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .OUT_REG   (OUT_REG),
    .INIT_FILE (INIT_FILE),
    .BE_W      (BE_W)
  ) u_bank (
    .clk     (clk),
    .i_clken (clken),
    .i_wr_en (w_run & w_gnt_any & w_gnt_wr),
    .i_rd_en (w_run & w_rd_fire),
    .i_addr  (w_addr),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_bank_rdata)
  );

  assign w_head = r_pipe[RSP_DEPTH-1];

  // A pending response is only shown while clken is high, so a freeze delays it.
  assign w_v1 = w_head.valid & (w_head.port == PORT_S1) & clken;
  assign w_v2 = w_head.valid & (w_head.port == PORT_S2) & clken;

  assign s1_readdatavalid = w_v1;
  assign s2_readdatavalid = w_v2;
  assign s1_readdata      = w_v1 ? w_bank_rdata : r_hold1;
  assign s2_readdata      = w_v2 ? w_bank_rdata : r_hold2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= PORT_S2;
      for (int i = 0; i < RSP_DEPTH; i++) r_pipe[i] <= '0;
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else if (clken) begin
      if (w_gnt_any) r_last <= w_gnt_port;
      r_pipe[0] <= '{valid: w_rd_fire, port: w_gnt_port};
      for (int i = 1; i < RSP_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      if (w_v1) r_hold1 <= w_bank_rdata;
      if (w_v2) r_hold2 <= w_bank_rdata;
    end
  end

endmodule

// File: tb/tb_qsys_lab_sram_arb.sv
// tb/tb_qsys_lab_sram_arb.sv - bench for qsys_lab_sram_arb, OUT_REG=0 and OUT_REG=1 side by side
module tb_qsys_lab_sram_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b1;
  logic [11:0] s1_address = '0, s2_address = '0;
  logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
  logic        s1_chipselect = 1'b0, s2_chipselect = 1'b0;
  logic        s1_read = 1'b0, s2_read = 1'b0;
  logic        s1_write = 1'b0, s2_write = 1'b0;
  logic [31:0] s1_writedata = '0, s2_writedata = '0;

  logic [31:0] d0_s1_readdata, d0_s2_readdata, d1_s1_readdata, d1_s2_readdata;
  logic        d0_s1_readdatavalid, d0_s2_readdatavalid, d1_s1_readdatavalid, d1_s2_readdatavalid;
  logic        d0_s1_waitrequest, d0_s2_waitrequest, d1_s1_waitrequest, d1_s2_waitrequest;

  always #5 clk = ~clk;

  qsys_lab_sram_arb #(.DATA_W(32), .ADDR_W(12), .OUT_REG(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(d0_s1_readdata), .s1_readdatavalid(d0_s1_readdatavalid), .s1_waitrequest(d0_s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(d0_s2_readdata), .s2_readdatavalid(d0_s2_readdatavalid), .s2_waitrequest(d0_s2_waitrequest)
  );

  qsys_lab_sram_arb #(.DATA_W(32), .ADDR_W(12), .OUT_REG(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(d1_s1_readdata), .s1_readdatavalid(d1_s1_readdatavalid), .s1_waitrequest(d1_s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(d1_s2_readdata), .s2_readdatavalid(d1_s2_readdatavalid), .s2_waitrequest(d1_s2_waitrequest)
  );

  logic        a_v [2][2];
  logic        a_w [2][2];
  logic [31:0] a_d [2][2];
  assign a_v[0][0] = d0_s1_readdatavalid; assign a_v[0][1] = d0_s2_readdatavalid;
  assign a_v[1][0] = d1_s1_readdatavalid; assign a_v[1][1] = d1_s2_readdatavalid;
  assign a_w[0][0] = d0_s1_waitrequest;   assign a_w[0][1] = d0_s2_waitrequest;
  assign a_w[1][0] = d1_s1_waitrequest;   assign a_w[1][1] = d1_s2_waitrequest;
  assign a_d[0][0] = d0_s1_readdata;      assign a_d[0][1] = d0_s2_readdata;
  assign a_d[1][0] = d1_s1_readdata;      assign a_d[1][1] = d1_s2_readdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input int p, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d s%0d cyc=%0d got=%h want=%h", nm, d, p + 1, cyc, act, exp);
    end
  endtask

  // Reference model: memory image, arbitration pointer, and per-DUT outstanding responses.
  typedef struct {
    bit          used;
    int          port;
    logic [31:0] data;
    int          cnt;
  } rec_t;

  logic [31:0] m_mem [4096];
  rec_t        m_slot [2][4];
  logic [31:0] m_hold [2][2];
  int          m_last = 1;

  function automatic bit m_req(input int p);
    if (p == 0) return s1_chipselect && (s1_read || s1_write);
    return s2_chipselect && (s2_read || s2_write);
  endfunction

  function automatic int m_grant();
    if (m_req(0) && m_req(1)) return (m_last == 1) ? 0 : 1;
    if (m_req(0)) return 0;
    if (m_req(1)) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int          g;
    bit          wr, placed;
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    if (!reset_n) begin
      m_last = 1;
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 4; s++) m_slot[d][s].used = 0;
        m_hold[d][0] = '0;
        m_hold[d][1] = '0;
      end
    end else if (clken) begin
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 4; s++)
          if (m_slot[d][s].used && m_slot[d][s].cnt == 0) begin
            m_hold[d][m_slot[d][s].port] = m_slot[d][s].data;
            m_slot[d][s].used = 0;
          end
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 4; s++)
          if (m_slot[d][s].used) m_slot[d][s].cnt--;
      g = m_grant();
      if (g >= 0) begin
        m_last = g;
        wr = (g == 0) ? s1_write : s2_write;
        a  = (g == 0) ? s1_address : s2_address;
        be = (g == 0) ? s1_byteenable : s2_byteenable;
        wd = (g == 0) ? s1_writedata : s2_writedata;
        if (wr) begin
          for (int i = 0; i < 4; i++) if (be[i]) m_mem[a][8*i +: 8] = wd[8*i +: 8];
        end else begin
          // latency 1 + OUT_REG: dut d presents after d further enabled edges
          for (int d = 0; d < 2; d++) begin
            placed = 0;
            for (int s = 0; s < 4; s++)
              if (!placed && !m_slot[d][s].used) begin
                m_slot[d][s] = '{used: 1, port: g, data: m_mem[a], cnt: d};
                placed = 1;
              end
          end
        end
      end
    end
  end

  int          n_p [2][2];
  int          first_c [2][2];
  int          last_c [2][2];
  logic [31:0] last_d [2][2];

  task automatic clr_log();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        n_p[d][p] = 0; first_c[d][p] = -1; last_c[d][p] = -1; last_d[d][p] = '0;
      end
  endtask

  always @(negedge clk) begin
    int          g;
    bit          ev, ew;
    logic [31:0] ed;
    g = m_grant();
    for (int p = 0; p < 2; p++) begin
      ew = !reset_n || !clken || (m_req(p) && g != p);
      for (int d = 0; d < 2; d++) begin
        chk("waitrequest", d, p, {31'd0, a_w[d][p]}, {31'd0, ew});
        ev = 0;
        ed = m_hold[d][p];
        if (!reset_n) ed = '0;
        else if (clken)
          for (int s = 0; s < 4; s++)
            if (m_slot[d][s].used && m_slot[d][s].cnt == 0 && m_slot[d][s].port == p) begin
              ev = 1; ed = m_slot[d][s].data;
            end
        chk("readdatavalid", d, p, {31'd0, a_v[d][p]}, {31'd0, ev});
        chk("readdata", d, p, a_d[d][p], ed);
        if (a_v[d][p]) begin
          if (n_p[d][p] == 0) first_c[d][p] = cyc;
          n_p[d][p]++;
          last_c[d][p] = cyc;
          last_d[d][p] = a_d[d][p];
        end
      end
    end
  end

  task automatic drive(input int p, input bit cs, input bit rd, input bit wr,
                       input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      s1_chipselect = cs; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = cs; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
  endtask

  task automatic access(input int p, input bit wr, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    bit ok;
    ok = 0;
    drive(p, 1, !wr, wr, a, be, d);
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = (p == 0) ? !d0_s1_waitrequest : !d0_s2_waitrequest;
    end
    chk("accept", 0, p, {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    drive(p, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    clr_log();
    step(2);
    @(negedge clk);
    chk("rst_wait", 0, 0, {31'd0, d0_s1_waitrequest}, 32'd1);
    chk("rst_data", 1, 1, d1_s2_readdata, 32'h0);
    chk("rst_valid", 0, 0, {31'd0, d0_s1_readdatavalid}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(1);

    // full-word write then read back on s1
    access(0, 1, 12'd5, 4'hF, 32'hDEADBEEF);
    access(0, 0, 12'd5, 4'hF, 32'h0);
    @(negedge clk);
    chk("t1_valid", 0, 0, {31'd0, d0_s1_readdatavalid}, 32'd1);
    chk("t1_data", 0, 0, d0_s1_readdata, 32'hDEADBEEF);
    chk("t1_s2_quiet", 0, 1, {31'd0, d0_s2_readdatavalid}, 32'd0);
    @(negedge clk);
    chk("t1_oreg_data", 1, 0, d1_s1_readdata, 32'hDEADBEEF);
    step(1);

    // single-lane write merges into existing word
    access(1, 1, 12'd5, 4'b0001, 32'h000000AA);
    access(1, 0, 12'd5, 4'hF, 32'h0);
    @(negedge clk);
    chk("t2_data", 0, 1, d0_s2_readdata, 32'hDEADBEAA);
    step(1);
    access(1, 1, 12'd6, 4'hF, 32'h00000066);
    access(1, 1, 12'd7, 4'hF, 32'h77777777);
    step(2);

    // continuous conflict: s1 wins first, then strict alternation
    clr_log();
    drive(0, 1, 1, 0, 12'd5, 4'hF, '0);
    drive(1, 1, 1, 0, 12'd6, 4'hF, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_wait_s1", 0, 0, {31'd0, d0_s1_waitrequest}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_wait_s2", 0, 1, {31'd0, d0_s2_waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, 0, '0, '0, '0);
    step(4);
    chk("t3_n_s1", 0, 0, n_p[0][0], 32'd2);
    chk("t3_n_s2", 0, 1, n_p[0][1], 32'd2);
    chk("t3_oreg_n_s2", 1, 1, n_p[1][1], 32'd2);
    chk("t3_s2_data", 0, 1, last_d[0][1], 32'h00000066);

    // back-to-back reads on s1: contiguous pulses, latency 2 with the output register
    clr_log();
    drive(0, 1, 1, 0, 12'd5, 4'hF, '0);
    step(1);
    acc = cyc;
    s1_address = 12'd6;
    step(1);
    s1_address = 12'd7;
    step(1);
    drive(0, 0, 0, 0, '0, '0, '0);
    step(5);
    chk("t4_n", 1, 0, n_p[1][0], 32'd3);
    chk("t4_first", 1, 0, first_c[1][0], acc + 1);
    chk("t4_last", 1, 0, last_c[1][0], acc + 3);
    chk("t4_last_data", 1, 0, last_d[1][0], 32'h77777777);
    chk("t4_first_nreg", 0, 0, first_c[0][0], acc);

    // clken freeze delays the pending pulse by three cycles
    clr_log();
    access(0, 0, 12'd6, 4'hF, 32'h0);
    acc = cyc;
    clken = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_wait_s1", 0, 0, {31'd0, d0_s1_waitrequest}, 32'd1);
      chk("t5_wait_s2", 1, 1, {31'd0, d1_s2_waitrequest}, 32'd1);
      chk("t5_no_pulse", 0, 0, {31'd0, d0_s1_readdatavalid}, 32'd0);
      @(posedge clk); #1;
    end
    clken = 1'b1;
    step(4);
    chk("t5_first", 0, 0, first_c[0][0], acc + 3);
    chk("t5_data", 0, 0, last_d[0][0], 32'h00000066);
    chk("t5_oreg_first", 1, 0, first_c[1][0], acc + 4);

    // reset with a read in flight: immediate clear, no late response, memory kept
    access(0, 0, 12'd5, 4'hF, 32'h0);
    clr_log();
    reset_n = 1'b0;
    #1;
    chk("t6_data", 0, 0, d0_s1_readdata, 32'h0);
    chk("t6_valid", 0, 0, {31'd0, d0_s1_readdatavalid}, 32'd0);
    chk("t6_wait", 0, 1, {31'd0, d0_s2_waitrequest}, 32'd1);
    step(2);
    reset_n = 1'b1;
    step(4);
    chk("t6_none0", 0, 0, n_p[0][0], 32'd0);
    chk("t6_none1", 1, 0, n_p[1][0], 32'd0);
    access(0, 0, 12'd5, 4'hF, 32'h0);
    @(negedge clk);
    chk("t6_kept", 0, 0, d0_s1_readdata, 32'hDEADBEAA);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
